// File: rtl/snake_body_ctrl.sv
// Snake body/head position controller with step timer and play FSM.
// Define WRAP_WALL_EN to make the playfield edges wrap instead of kill.
module snake_body_ctrl #(
  parameter int TICK_DIV = 12_500_000,
  parameter int MAX_LEN  = 16
) (
  input  logic                  CLK_50M,
  input  logic                  RST,
  input  logic [3:0]            key,
  input  logic                  add_cube,
  output logic [5:0]            head_x,
  output logic [5:0]            head_y,
  output logic [6*MAX_LEN-1:0]  body_x,
  output logic [6*MAX_LEN-1:0]  body_y,
  output logic [MAX_LEN-1:0]    cube_num,
  output logic [1:0]            game_status
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DIE  = 2'd2
  } state_t;

  // Directions are one-hot in the same order as key: {up,down,left,right}
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [LW-1:0]            len_q, len_d;
  logic [MAX_LEN-1:0][5:0]  seg_x_q, seg_x_d;
  logic [MAX_LEN-1:0][5:0]  seg_y_q, seg_y_d;
  logic [3:0]               dir_q, dir_d;
  logic [3:0]               pend_q, pend_d;
  logic                     grow_q, grow_d;
  logic                     seen_q, seen_d;

  logic        tick;
  logic        grow_eff;
  logic        can_grow;
  logic [3:0]  rev_dir;
  logic        key_ok;
  logic [3:0]  pend_n;
  logic [5:0]  nx, ny;
  logic        self_hit;
  logic        hit;

  always_comb begin
    tick     = (cnt_q == CW'(TICK_DIV - 1));
    grow_eff = grow_q | add_cube;
    can_grow = grow_eff && (len_q < LW'(MAX_LEN));
    rev_dir  = {dir_q[2], dir_q[3], dir_q[0], dir_q[1]};
    key_ok   = $onehot(key) && (key != rev_dir);
    pend_n   = key_ok ? key : pend_q;

    nx = seg_x_q[0];
    ny = seg_y_q[0];
    unique case (1'b1)
      pend_q[3]: ny = seg_y_q[0] - 6'd1;
      pend_q[2]: ny = seg_y_q[0] + 6'd1;
      pend_q[1]: nx = seg_x_q[0] - 6'd1;
      default:   nx = seg_x_q[0] + 6'd1;
    endcase

`ifdef WRAP_WALL_EN
    if (nx == 6'd0) nx = 6'd38;
    else if (nx == 6'd39) nx = 6'd1;
    if (ny == 6'd0) ny = 6'd28;
    else if (ny == 6'd29) ny = 6'd1;
`endif

    // Tail is vacating unless this step also grows the snake
    self_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((i + 2 <= int'(len_q) ||
           (can_grow && i + 1 <= int'(len_q))) &&
          seg_x_q[i] == nx && seg_y_q[i] == ny)
        self_hit = 1'b1;
    end

`ifdef WRAP_WALL_EN
    hit = self_hit;
`else
    hit = self_hit ||
          nx == 6'd0 || nx == 6'd39 ||
          ny == 6'd0 || ny == 6'd29;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + CW'(1);
    len_d   = len_q;
    seg_x_d = seg_x_q;
    seg_y_d = seg_y_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    grow_d  = grow_q;
    seen_d  = seen_q;

    unique case (state_q)
      S_IDLE: begin
        grow_d = grow_eff;
        pend_d = pend_n;
        if (|key) state_d = S_PLAY;
      end
      S_PLAY: begin
        grow_d = grow_eff;
        pend_d = pend_n;
        if (tick) begin
          grow_d = 1'b0;
          if (hit) begin
            state_d = S_DIE;
            seen_d  = 1'b0;
          end else begin
            dir_d   = pend_q;
            seg_x_d = {seg_x_q[MAX_LEN-2:0], nx};
            seg_y_d = {seg_y_q[MAX_LEN-2:0], ny};
            if (can_grow) len_d = len_q + LW'(1);
          end
        end
      end
      S_DIE: begin
        grow_d = grow_eff;
        if (seen_q && |key) begin
          state_d    = S_IDLE;
          len_d      = LW'(3);
          seg_x_d    = '0;
          seg_y_d    = '0;
          seg_x_d[0] = 6'd5;
          seg_x_d[1] = 6'd4;
          seg_x_d[2] = 6'd3;
          seg_y_d[0] = 6'd5;
          seg_y_d[1] = 6'd5;
          seg_y_d[2] = 6'd5;
          dir_d      = DIR_RIGHT;
          pend_d     = DIR_RIGHT;
          grow_d     = 1'b0;
          seen_d     = 1'b0;
        end else begin
          seen_d = seen_q | ~|key;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      len_q      <= LW'(3);
      seg_x_q    <= '0;
      seg_y_q    <= '0;
      seg_x_q[0] <= 6'd5;
      seg_x_q[1] <= 6'd4;
      seg_x_q[2] <= 6'd3;
      seg_y_q[0] <= 6'd5;
      seg_y_q[1] <= 6'd5;
      seg_y_q[2] <= 6'd5;
      dir_q      <= DIR_RIGHT;
      pend_q     <= DIR_RIGHT;
      grow_q     <= 1'b0;
      seen_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      seg_x_q <= seg_x_d;
      seg_y_q <= seg_y_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      grow_q  <= grow_d;
      seen_q  <= seen_d;
    end
  end

  always_comb begin
    cube_num = '0;
    for (int i = 0; i < MAX_LEN; i++)
      cube_num[i] = (LW'(i) < len_q);
  end

  assign head_x      = seg_x_q[0];
  assign head_y      = seg_y_q[0];
  assign body_x      = seg_x_q;
  assign body_y      = seg_y_q;
  assign game_status = state_q;

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Scoreboard bench for snake_body_ctrl: directed scenarios plus random
// key/grow/reset traffic checked against a list-of-segments model.
module tb_snake_body_ctrl;

  localparam int TD = 4;
  localparam int ML = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      key = 4'b0000;
  logic            add = 1'b0;
  logic [5:0]      head_x, head_y;
  logic [6*ML-1:0] body_x, body_y;
  logic [ML-1:0]   cube_num;
  logic [1:0]      game_status;

  always #5 clk = ~clk;

  snake_body_ctrl #(.TICK_DIV(TD), .MAX_LEN(ML)) dut (
    .CLK_50M    (clk),
    .RST        (rst),
    .key        (key),
    .add_cube   (add),
    .head_x     (head_x),
    .head_y     (head_y),
    .body_x     (body_x),
    .body_y     (body_y),
    .cube_num   (cube_num),
    .game_status(game_status)
  );

  typedef struct {
    logic [1:0]      st;
    logic [5:0]      hx, hy;
    logic [6*ML-1:0] bx, by;
    logic [ML-1:0]   cn;
  } snap_t;

  snap_t exp_q[$];
  snap_t e;
  int n_vec = 0;
  int n_bad = 0;

  // Reference model: 0 up, 1 down, 2 left, 3 right
  int DX[4] = '{0, 0, -1, 1};
  int DY[4] = '{-1, 1, 0, 0};
  int m_cnt, m_st, m_len, m_dir, m_pend;
  int m_sx[ML];
  int m_sy[ML];
  bit m_grow, m_seen, m_tick;

  function automatic int key_dir(logic [3:0] k);
    case (k)
      4'b1000: return 0;
      4'b0100: return 1;
      4'b0010: return 2;
      4'b0001: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic void snake_init();
    m_st  = 0;
    m_len = 3;
    for (int i = 0; i < ML; i++) begin
      m_sx[i] = (i < 3) ? 5 - i : 0;
      m_sy[i] = (i < 3) ? 5 : 0;
    end
    m_dir  = 3;
    m_pend = 3;
    m_grow = 0;
    m_seen = 0;
  endfunction

  function automatic void model_reset();
    snake_init();
    m_cnt  = 0;
    m_tick = 0;
  endfunction

  function automatic void model_step(logic [3:0] k, bit a);
    bit tk, ge, cg, hit;
    int kd, pn, op, nx, ny;
    tk     = (m_cnt == TD - 1);
    m_tick = tk;
    m_cnt  = tk ? 0 : m_cnt + 1;
    ge     = m_grow | a;
    kd     = key_dir(k);
    pn     = m_pend;
    if (kd >= 0 && !(DX[kd] == -DX[m_dir] && DY[kd] == -DY[m_dir]))
      pn = kd;
    case (m_st)
      0: begin
        m_grow = ge;
        m_pend = pn;
        if (k != 0) m_st = 1;
      end
      1: begin
        op     = m_pend;
        m_pend = pn;
        m_grow = ge;
        if (tk) begin
          m_grow = 0;
          nx  = m_sx[0] + DX[op];
          ny  = m_sy[0] + DY[op];
          hit = 0;
`ifdef WRAP_WALL_EN
          if (nx < 1) nx = 38;
          if (nx > 38) nx = 1;
          if (ny < 1) ny = 28;
          if (ny > 28) ny = 1;
`else
          if (nx < 1 || nx > 38 || ny < 1 || ny > 28) hit = 1;
`endif
          cg = ge && m_len < ML;
          for (int i = 1; i < ML; i++)
            if ((i <= m_len - 2 || (cg && i <= m_len - 1)) &&
                m_sx[i] == nx && m_sy[i] == ny)
              hit = 1;
          if (hit) begin
            m_st   = 2;
            m_seen = 0;
          end else begin
            m_dir = op;
            for (int i = ML - 1; i > 0; i--) begin
              m_sx[i] = m_sx[i-1];
              m_sy[i] = m_sy[i-1];
            end
            m_sx[0] = nx;
            m_sy[0] = ny;
            if (cg) m_len++;
          end
        end
      end
      default: begin
        m_grow = ge;
        if (m_seen && k != 0) snake_init();
        else if (k == 0) m_seen = 1;
      end
    endcase
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.st = 2'(m_st);
    s.hx = 6'(m_sx[0]);
    s.hy = 6'(m_sy[0]);
    s.bx = '0;
    s.by = '0;
    s.cn = '0;
    for (int i = 0; i < ML; i++) begin
      s.bx[6*i +: 6] = 6'(m_sx[i]);
      s.by[6*i +: 6] = 6'(m_sy[i]);
      s.cn[i]        = (i < m_len);
    end
    return s;
  endfunction

  // Monitor: every cycle the DUT presents a new state after the edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (game_status !== e.st || head_x !== e.hx || head_y !== e.hy ||
          body_x !== e.bx || body_y !== e.by || cube_num !== e.cn) begin
        n_bad++;
        $display("FAIL cycle t=%0t st=%0d/%0d head=(%0d,%0d)/(%0d,%0d) cube=%h/%h bx=%h/%h by=%h/%h",
                 $time, game_status, e.st, head_x, head_y, e.hx, e.hy,
                 cube_num, e.cn, body_x, e.bx, body_y, e.by);
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(logic [3:0] k, bit a, bit r);
    @(negedge clk);
    rst = r;
    key = k;
    add = a;
    if (r) model_reset();
    else model_step(k, a);
    exp_q.push_back(model_snap());
  endtask

  task automatic step_with(logic [3:0] k, bit a);
    int n;
    drive(k, a, 1'b0);
    n = 0;
    while (!m_tick && n < 4 * TD) begin
      drive(4'b0000, 1'b0, 1'b0);
      n++;
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_st", int'(game_status), 0);
    chk("async_rst_hx", int'(head_x), 5);
    chk("async_rst_cube", int'(cube_num), 'h7);
    @(negedge clk);
    exp_q.push_back(model_snap());
  endtask

  initial begin
    int n;
    int sel;
    logic [3:0] k;
    bit a, r;
    model_reset();

    drive(4'b0000, 1'b0, 1'b1);
    drive(4'b0000, 1'b0, 1'b1);
    settle();
    chk("rst_st", int'(game_status), 0);
    chk("rst_hx", int'(head_x), 5);
    chk("rst_hy", int'(head_y), 5);
    chk("rst_seg1x", int'(body_x[11:6]), 4);
    chk("rst_cube", int'(cube_num), 'h7);

    step_with(4'b0001, 1'b0);
    step_with(4'b0000, 1'b0);
    step_with(4'b0000, 1'b0);
    settle();
    chk("start_st", int'(game_status), 1);
    chk("start_hx", int'(head_x), 8);
    chk("start_hy", int'(head_y), 5);
    chk("start_seg1x", int'(body_x[11:6]), 7);
    chk("start_seg2x", int'(body_x[17:12]), 6);
    chk("start_cube", int'(cube_num), 'h7);

    step_with(4'b0010, 1'b0);
    settle();
    chk("reverse_hx", int'(head_x), 9);
    chk("reverse_hy", int'(head_y), 5);
    step_with(4'b1000, 1'b0);
    settle();
    chk("up_hx", int'(head_x), 9);
    chk("up_hy", int'(head_y), 4);

    step_with(4'b0000, 1'b1);
    settle();
    chk("grow_cube", int'(cube_num), 'hF);
    chk("grow_tailx", int'(body_x[23:18]), 8);
    chk("grow_taily", int'(body_y[23:18]), 5);
    for (int i = 0; i < 13; i++) step_with(4'b0001, 1'b1);
    settle();
    chk("sat_cube", int'(cube_num), 'hFFFF);
    chk("sat_hx", int'(head_x), 22);

    n = 0;
    while (m_sx[0] != 38 && n < 40) begin
      step_with(4'b0000, 1'b0);
      n++;
    end
    step_with(4'b0000, 1'b0);
    settle();
`ifdef WRAP_WALL_EN
    chk("wall_st", int'(game_status), 1);
    chk("wall_hx", int'(head_x), 1);
`else
    chk("wall_st", int'(game_status), 2);
    chk("wall_hx", int'(head_x), 38);
`endif
    chk("wall_hy", int'(head_y), 3);

    drive(4'b0000, 1'b0, 1'b1);
    step_with(4'b0001, 1'b1);
    step_with(4'b0000, 1'b0);
    step_with(4'b0100, 1'b0);
    step_with(4'b0010, 1'b0);
    step_with(4'b1000, 1'b0);
    step_with(4'b0001, 1'b0);
    step_with(4'b0100, 1'b0);
    settle();
    chk("chase_st", int'(game_status), 1);
    chk("chase_hx", int'(head_x), 7);
    chk("chase_hy", int'(head_y), 6);

    drive(4'b0000, 1'b0, 1'b1);
    step_with(4'b0001, 1'b1);
    step_with(4'b0000, 1'b1);
    step_with(4'b0000, 1'b0);
    step_with(4'b0100, 1'b0);
    step_with(4'b0010, 1'b0);
    step_with(4'b1000, 1'b0);
    settle();
    chk("self_st", int'(game_status), 2);
    chk("self_hx", int'(head_x), 7);
    chk("self_hy", int'(head_y), 6);
    chk("self_cube", int'(cube_num), 'h1F);

    drive(4'b0001, 1'b0, 1'b0);
    settle();
    chk("die_hold_st", int'(game_status), 2);
    drive(4'b0000, 1'b0, 1'b0);
    drive(4'b0001, 1'b0, 1'b0);
    settle();
    chk("restart_st", int'(game_status), 0);
    chk("restart_hx", int'(head_x), 5);
    chk("restart_cube", int'(cube_num), 'h7);

    step_with(4'b0001, 1'b0);
    drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0000, 1'b0, 1'b0);
    mid_reset();
    step_with(4'b0001, 1'b0);
    settle();
    chk("post_rst_cube", int'(cube_num), 'h7);
    chk("post_rst_hx", int'(head_x), 6);

    for (int i = 0; i < 1500; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6) k = 4'b0000;
      else if (sel < 9) k = 4'(1 << $urandom_range(0, 3));
      else k = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 299) == 0);
      drive(k, a, r);
    end

    repeat (2) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/snake_body_ctrl.md
SNAKE_BODY_CTRL -- requirements
Module: snake_body_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 12_500_000, meaning clock cycles per movement step (0.25 s at 50 MHz).
REQ-002 The block SHALL have parameter MAX_LEN, default 16, meaning maximum segment count, head included.
REQ-003 CLK_50M  input  1  sole clock; all logic on rising edge.
REQ-004 RST  input  1  reset, asynchronous assert, active-high.
REQ-005 key  input  4  direction request {up,down,left,right}, level-sensitive, sampled every clock.
REQ-006 add_cube  input  1  one-cycle grow pulse from the apple block.
REQ-007 head_x  output  6  head column; head_y  output  6  head row (registered).
REQ-008 body_x  output  6*MAX_LEN  segment columns, segment i at bits [6i+5:6i], i=0 is head; body_y likewise for rows.
REQ-009 cube_num  output  MAX_LEN  valid mask, bit i set when segment i exists.
REQ-010 game_status  output  2  0=IDLE, 1=PLAY, 2=DIE.

Function
REQ-011 Playfield SHALL be x 1..38, y 1..28; x=0, x=39, y=0, y=29 are walls.
REQ-012 A step counter SHALL count 0..TICK_DIV-1 and wrap; the wrap cycle is the step tick; counter runs in all states.
REQ-013 FSM: IDLE -> PLAY on any key bit high; PLAY -> DIE on collision at a step tick; DIE -> IDLE on any key bit high after all keys were seen low at least one clock in DIE.
REQ-014 Entering IDLE from DIE SHALL restore the reset snake (REQ-024) in the same cycle.
REQ-015 Pending direction SHALL update from key when exactly one bit is set and it is not the reverse of the currently applied direction; otherwise unchanged; priority not needed since multi-bit keys are ignored.
REQ-016 On a PLAY step tick: applied direction <= pending; new head = head + unit vector (up decreases y, left decreases x).
REQ-017 Move: segment[i] <= segment[i-1] for i=1..MAX_LEN-1; segment[0] <= new head; head_x/head_y equal segment[0].
REQ-018 add_cube pulse SHALL set a sticky grow flag in the cycle it arrives, in any state; the flag clears at the next PLAY step tick.
REQ-019 At a step tick with grow flag set and length < MAX_LEN, length SHALL increase by 1 (new tail = old tail position); at length = MAX_LEN growth is discarded.
REQ-020 add_cube coinciding with a step tick SHALL take effect at that tick.
REQ-021 Wall collision: new head on a wall -> DIE, no segment moves, length unchanged.
REQ-022 Self collision: new head equals current segment i for 1 <= i <= length-2 (tail excluded unless growing, then i <= length-1) -> DIE, no move.
REQ-023 No movement, growth or direction apply in IDLE or DIE; outputs hold.

Reset
REQ-024 While RST high: state IDLE, counter 0, length 3, segments 0..2 = (5,5),(4,5),(3,5), others (0,0), direction and pending = right, grow flag 0, cube_num = 3'b111 zero-extended, head_x=5, head_y=5.
REQ-025 Reset asserted mid-step or mid-growth SHALL discard all pending actions immediately.

Configuration
REQ-026 Macro WRAP_WALL_EN: when defined, wall moves wrap (x 39->1, x 0->38, y 29->1, y 0->28) and only self collision causes DIE; when undefined, REQ-021 applies.

Verification (TICK_DIV=4, MAX_LEN=16)
REQ-027 Reset, key=0001 one clock, three ticks -> game_status 1, head (8,5), body (7,5),(6,5), cube_num 0x0007.
REQ-028 In PLAY moving right, key=0010 (left, reverse) then tick -> ignored, head x+1; key=1000 then tick -> head y-1.
REQ-029 add_cube one cycle mid-step -> next tick length 4, cube_num 0x000F, tail holds old tail position; 13 further pulses -> length saturates at 16, cube_num 0xFFFF.
REQ-030 Head (38,5) moving right, tick -> game_status 2, head stays (38,5); with WRAP_WALL_EN -> head (1,5), status 1.
REQ-031 Length 5, U-turn path into own segment 3 -> DIE at that tick; chasing tail at length 4 without growth -> no DIE.
REQ-032 In DIE, keys low then key=0001 -> IDLE with reset snake; RST pulse mid-step -> REQ-024 values immediately.
